// File: rtl/alu_dispatch.sv
`timescale 1ns/1ps
// Dispatch/writeback stage in front of the 16-bit ALU: 8x16 regfile, IDLE/ISSUE/WAIT/WB FSM, illegal-op and timeout traps.
// ALU op: accept -> WB after 3 + ALU busy cycles; instr_ready only in IDLE. Optional {Z,N,C} flags under DISPATCH_FLAGS_EN.
module alu_dispatch #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [4:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_cin,
   output logic        alu_bin,
   output logic        alu_mov_enable,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_remainder,
   input  logic        alu_bout,
   input  logic        alu_busy,
   output logic        done,
   output logic        err_illegal,
   output logic        err_timeout,
   input  logic [2:0]  dbg_addr,
`ifdef DISPATCH_FLAGS_EN
   output logic [2:0]  flags,
`endif
   output logic [15:0] dbg_data
);

   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_DIV = 5'b00100;
   localparam logic [4:0] OP_MOV = 5'b01000;
   localparam logic [4:0] OP_LDI = 5'b11111;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

   state_t      state, state_n;
   logic [4:0]  op_q;
   logic [2:0]  rd_q;
   logic [15:0] res_q;
   logic [15:0] rem_q;
   logic [7:0]  wait_cnt;
   logic        err_ill_q;
   logic        err_to_q;
   logic [15:0] regs [8];

   logic [4:0]  in_op;
   logic [2:0]  in_rd, in_ra, in_rb;
   logic        accept, in_alu, in_ldi, alu_finish, timed_out;

   function automatic logic is_alu_op(input logic [4:0] op);
      return (op >= 5'd1 && op <= 5'd6) || (op >= 5'd8 && op <= 5'd17);
   endfunction

   assign in_op  = instr[15:11];
   assign in_rd  = instr[10:8];
   assign in_ra  = instr[7:5];
   assign in_rb  = instr[4:2];
   assign accept = instr_valid && (state == S_IDLE);
   assign in_alu = is_alu_op(in_op);
   assign in_ldi = (in_op == OP_LDI);

   // wait_cnt == 0 marks the first WAIT cycle, where busy may not yet reflect the new op.
   assign alu_finish = (state == S_WAIT) && (wait_cnt != 8'd0) && !alu_busy;
   assign timed_out  = (state == S_WAIT) && !alu_finish && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (accept && in_alu)      state_n = S_ISSUE;
            else if (accept && in_ldi) state_n = S_WB;
         end
         S_ISSUE: state_n = S_WAIT;
         S_WAIT: begin
            if (alu_finish)     state_n = S_WB;
            else if (timed_out) state_n = S_IDLE;
         end
         S_WB:    state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q      <= 5'd0;
         rd_q      <= 3'd0;
         res_q     <= 16'd0;
         rem_q     <= 16'd0;
         alu_a     <= 16'd0;
         alu_b     <= 16'd0;
         wait_cnt  <= 8'd0;
         err_ill_q <= 1'b0;
         err_to_q  <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
      end else begin
         err_ill_q <= accept && !in_alu && !in_ldi;
         err_to_q  <= timed_out;
         if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            alu_a <= regs[in_ra];
            alu_b <= regs[in_rb];
            res_q <= {8'h00, instr[7:0]};
         end
         if (state == S_ISSUE)     wait_cnt <= 8'd0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
         if (alu_finish) begin
            res_q <= alu_result;
            rem_q <= alu_remainder;
         end
         if (state == S_WB) begin
            regs[rd_q] <= res_q;
            // rd+1 wraps within 3 bits, so a DIV into r7 puts the remainder in r0.
            if (op_q == OP_DIV) regs[rd_q + 3'd1] <= rem_q;
         end
      end
   end

`ifdef DISPATCH_FLAGS_EN
   logic bout_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bout_q <= 1'b0;
         flags  <= 3'b000;
      end else begin
         if (alu_finish) bout_q <= alu_bout;
         if (state == S_WB && op_q != OP_LDI) begin
            flags[2] <= (res_q == 16'd0);
            flags[1] <= res_q[15];
            if (op_q == OP_SUB) flags[0] <= bout_q;
         end
      end
   end
`else
   logic unused_bout;
   assign unused_bout = alu_bout;
`endif

   assign instr_ready    = (state == S_IDLE);
   assign alu_op         = (state == S_ISSUE) ? op_q : 5'd0;
   assign alu_cin        = 1'b0;
   assign alu_bin        = 1'b0;
   assign alu_mov_enable = (op_q == OP_MOV);
   assign done           = (state == S_WB) || err_ill_q || err_to_q;
   assign err_illegal    = err_ill_q;
   assign err_timeout    = err_to_q;
   assign dbg_data       = regs[dbg_addr];

endmodule

// File: tb/tb_alu_dispatch.sv
`timescale 1ns/1ps
// Randomized bench for alu_dispatch: behavioural ALU stand-in plus a regfile/flags reference model.
module tb_alu_dispatch;

   localparam int TMO = 64;
   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_DIV = 5'b00100;
   localparam logic [4:0] OP_MOV = 5'b01000;
   localparam logic [4:0] OP_LDI = 5'b11111;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  alu_op;
   logic [15:0] alu_a, alu_b;
   logic        alu_cin, alu_bin, alu_mov_enable;
   logic [15:0] alu_result, alu_remainder;
   logic        alu_bout, alu_busy;
   logic        done, err_illegal, err_timeout;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
`ifdef DISPATCH_FLAGS_EN
   logic [2:0]  flags;
`endif

   alu_dispatch #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cin(alu_cin), .alu_bin(alu_bin), .alu_mov_enable(alu_mov_enable),
      .alu_result(alu_result), .alu_remainder(alu_remainder),
      .alu_bout(alu_bout), .alu_busy(alu_busy),
      .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout),
      .dbg_addr(dbg_addr),
`ifdef DISPATCH_FLAGS_EN
      .flags(flags),
`endif
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] mreg [8];
   logic [2:0]  mflags = 3'b000;
   int lat_cfg  = 1;
   bit hang_cfg = 1'b0;
   int alu_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // {bout, remainder, result}
   function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r, m;
      logic        bo;
      r = 16'd0; m = 16'd0; bo = 1'b0;
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: begin r = a - b; bo = (a < b); end
         OP_DIV: begin
            if (b == 16'd0) begin r = 16'hffff; m = a; end
            else begin r = a / b; m = a % b; end
         end
         OP_MOV: r = a;
         default: r = (a ^ b) + {11'd0, op};
      endcase
      return {bo, m, r};
   endfunction

   // ALU stand-in: busy for lat_cfg cycles after the issue edge, or forever when hung.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_busy <= 1'b0; alu_result <= 16'd0; alu_remainder <= 16'd0;
         alu_bout <= 1'b0; alu_left <= 0;
      end else if (alu_op != 5'd0) begin
         {alu_bout, alu_remainder, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
         alu_busy <= 1'b1;
         alu_left <= lat_cfg;
      end else if (alu_busy && !hang_cfg) begin
         if (alu_left <= 1) alu_busy <= 1'b0;
         else alu_left <= alu_left - 1;
      end
   end

   function automatic logic [15:0] mk(input logic [4:0] op, input int rd, input int ra, input int rb);
      return {op, 3'(rd), 3'(ra), 3'(rb), 2'b00};
   endfunction

   function automatic logic [15:0] mk_ldi(input int rd, input logic [7:0] imm);
      return {OP_LDI, 3'(rd), imm};
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("%s_r%0d", tag, i), {16'd0, dbg_data}, {16'd0, mreg[i]});
      end
`ifdef DISPATCH_FLAGS_EN
      check({tag, "_flags"}, {29'd0, flags}, {29'd0, mflags});
`endif
   endtask

   task automatic run_instr(input logic [15:0] ins);
      logic [4:0]  op;
      logic [2:0]  rd, ra, rb;
      logic [32:0] r;
      bit is_alu, is_ldi, is_ill;
      int c, exp_lat;
      op = ins[15:11]; rd = ins[10:8]; ra = ins[7:5]; rb = ins[4:2];
      is_alu = op inside {[5'd1:5'd6], [5'd8:5'd17]};
      is_ldi = (op == OP_LDI);
      is_ill = !is_alu && !is_ldi;
      exp_lat = is_alu ? (hang_cfg ? 2 + TMO : 3 + lat_cfg) : 1;

      @(negedge clk);
      check("ready_idle", {31'd0, instr_ready}, 32'd1);
      instr = ins; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      c = 1;
      check("ready_t1", {31'd0, instr_ready}, {31'd0, is_ill});
      check("alu_op_t1", {27'd0, alu_op}, is_alu ? {27'd0, op} : 32'd0);
      check("mov_en", {31'd0, alu_mov_enable}, {31'd0, (op == OP_MOV)});
      if (is_alu) begin
         check("alu_a", {16'd0, alu_a}, {16'd0, mreg[ra]});
         check("alu_b", {16'd0, alu_b}, {16'd0, mreg[rb]});
      end
      while (!done && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("done_latency", c, exp_lat);
      check("err_illegal", {31'd0, err_illegal}, {31'd0, is_ill});
      check("err_timeout", {31'd0, err_timeout}, {31'd0, (is_alu && hang_cfg)});
      check("ready_at_done", {31'd0, instr_ready}, {31'd0, !(is_ldi || (is_alu && !hang_cfg))});

      if (is_ldi) mreg[rd] = {8'h00, ins[7:0]};
      else if (is_alu && !hang_cfg) begin
         r = alu_fn(op, mreg[ra], mreg[rb]);
         mreg[rd] = r[15:0];
         if (op == OP_DIV) mreg[(int'(rd) + 1) % 8] = r[31:16];
         mflags[2] = (r[15:0] == 16'd0);
         mflags[1] = r[15];
         if (op == OP_SUB) mflags[0] = r[32];
      end

      @(negedge clk);
      check("done_single", {31'd0, done}, 32'd0);
      check("ready_after", {31'd0, instr_ready}, 32'd1);
      check_regs("reg");
   endtask

   initial begin
      logic [4:0] rop;
      int v;
      rst = 1'b0; instr = 16'd0; instr_valid = 1'b0; dbg_addr = 3'd0;
      for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_alu_op", {27'd0, alu_op}, 32'd0);
      check("rst_cin_bin", {30'd0, alu_cin, alu_bin}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check_regs("rst");

      // LDI + ADD
      run_instr(mk_ldi(1, 8'd10));
      run_instr(mk_ldi(2, 8'd5));
      run_instr(mk(OP_ADD, 3, 1, 2));
      dbg_addr = 3'd3; #1;
      check("add_r3_15", {16'd0, dbg_data}, 32'd15);

      // DIV into r7: remainder wraps to r0
      run_instr(mk_ldi(1, 8'd15));
      run_instr(mk_ldi(2, 8'd7));
      run_instr(mk(OP_DIV, 7, 1, 2));
      dbg_addr = 3'd7; #1;
      check("div_r7", {16'd0, dbg_data}, 32'd2);
      dbg_addr = 3'd0; #1;
      check("div_r0", {16'd0, dbg_data}, 32'd1);

      // Illegal op
      run_instr(mk(5'b00111, 4, 1, 2));

      // Flags scenario and ra == rd
      run_instr(mk_ldi(1, 8'd5));
      run_instr(mk_ldi(2, 8'd3));
      run_instr(mk(OP_SUB, 4, 1, 1));
`ifdef DISPATCH_FLAGS_EN
      check("flags_sub_zero", {29'd0, flags}, 32'b100);
`endif
      run_instr(mk(OP_SUB, 5, 2, 1));
`ifdef DISPATCH_FLAGS_EN
      check("flags_sub_borrow", {29'd0, flags}, 32'b011);
`endif
      run_instr(mk_ldi(6, 8'd0));
`ifdef DISPATCH_FLAGS_EN
      check("flags_after_ldi", {29'd0, flags}, 32'b011);
`endif
      run_instr(mk(OP_ADD, 1, 1, 2));
      run_instr(mk(OP_MOV, 6, 5, 0));

      // Randomized mix
      for (int n = 0; n < 60; n++) begin
         v = $urandom_range(0, 9);
         lat_cfg = $urandom_range(1, 4);
         if (v < 2) run_instr(mk_ldi($urandom_range(0, 7), 8'($urandom)));
         else begin
            if (v == 2) begin
               v = $urandom_range(0, 14);
               rop = (v == 0) ? 5'd0 : (v == 1) ? 5'd7 : 5'(v + 16);
            end else begin
               v = $urandom_range(0, 15);
               rop = (v < 6) ? 5'(v + 1) : 5'(v + 2);
            end
            run_instr(mk(rop, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
         end
      end

      // Timeout: ALU never drops busy
      lat_cfg = 1;
      hang_cfg = 1'b1;
      run_instr(mk(OP_ADD, 5, 1, 2));
      hang_cfg = 1'b0;
      run_instr(mk(OP_ADD, 5, 1, 2));

      // Reset in the middle of WAIT
      hang_cfg = 1'b1;
      @(negedge clk);
      instr = mk(OP_ADD, 2, 1, 3); instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      hang_cfg = 1'b0;
      #1;
      check("midrst_alu_op", {27'd0, alu_op}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
      mflags = 3'b000;
      check_regs("midrst");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postrst_no_done", {30'd0, done, err_timeout}, 32'd0);
      end
      check("postrst_ready", {31'd0, instr_ready}, 32'd1);
      run_instr(mk_ldi(1, 8'd200));
      run_instr(mk(OP_ADD, 2, 1, 1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
